// File: rtl/pulse_wave_gen_pkg.sv
// Shared encodings and reset defaults for the rectangular-wave generator.
package pulse_gen_pkg;

  localparam logic [1:0] MODE_CONT  = 2'b00;
  localparam logic [1:0] MODE_INV   = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2
  } state_e;

  localparam int DEF_PERIOD = 100;
  localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/pulse_wave_gen_if.sv
// Configuration, step/trigger and DAC-code bundle between the frequency divider side and the generator.
interface pulse_wave_gen_if #(
  parameter int DATA_W  = 12,
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
);
  logic               tick;
  logic               load;
  logic [CNT_W-1:0]   period;
  logic [CNT_W-1:0]   duty;
  logic [DATA_W-1:0]  minimum;
  logic [DATA_W-1:0]  maximum;
  logic [1:0]         mode;
  logic [BURST_W-1:0] burst_len;
  logic               trigger;
  logic [DATA_W-1:0]  waveform;
  logic               sync;
  logic               busy;

  modport master (
    output tick, load, period, duty, minimum, maximum, mode, burst_len, trigger,
    input  waveform, sync, busy
  );

  modport slave (
    input  tick, load, period, duty, minimum, maximum, mode, burst_len, trigger,
    output waveform, sync, busy
  );
endinterface

// File: rtl/pulse_cfg_shadow.sv
// Shadow/active configuration pair: load captures into shadow, copies to active at period boundaries or while idle.
// Outputs the set in force for the current tick; shadow is presented directly during a boundary copy.
module pulse_cfg_shadow
  import pulse_gen_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               copy_idle,
  input  logic               copy_bnd,
  input  logic [CNT_W-1:0]   period_i,
  input  logic [CNT_W-1:0]   duty_i,
  input  logic [DATA_W-1:0]  min_i,
  input  logic [DATA_W-1:0]  max_i,
  input  logic [1:0]         mode_i,
  input  logic [BURST_W-1:0] blen_i,
  output logic [CNT_W-1:0]   period_o,
  output logic [CNT_W-1:0]   duty_o,
  output logic [DATA_W-1:0]  min_o,
  output logic [DATA_W-1:0]  max_o,
  output logic [1:0]         mode_o,
  output logic [BURST_W-1:0] blen_o
);

  logic [CNT_W-1:0]   sh_period_q, sh_period_d, act_period_q, act_period_d;
  logic [CNT_W-1:0]   sh_duty_q, sh_duty_d, act_duty_q, act_duty_d;
  logic [DATA_W-1:0]  sh_min_q, sh_min_d, act_min_q, act_min_d;
  logic [DATA_W-1:0]  sh_max_q, sh_max_d, act_max_q, act_max_d;
  logic [1:0]         sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
  logic [BURST_W-1:0] sh_blen_q, sh_blen_d, act_blen_q, act_blen_d;
  logic [CNT_W-1:0]   period_clamped;

  // Periods below two cannot alternate high and low, so they are raised at capture.
  assign period_clamped = (period_i < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period_i;

  always_comb begin
    sh_period_d  = sh_period_q;
    sh_duty_d    = sh_duty_q;
    sh_min_d     = sh_min_q;
    sh_max_d     = sh_max_q;
    sh_mode_d    = sh_mode_q;
    sh_blen_d    = sh_blen_q;
    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;
    act_min_d    = act_min_q;
    act_max_d    = act_max_q;
    act_mode_d   = act_mode_q;
    act_blen_d   = act_blen_q;
    if (load) begin
      sh_period_d = period_clamped;
      sh_duty_d   = duty_i;
      sh_min_d    = min_i;
      sh_max_d    = max_i;
      sh_mode_d   = mode_i;
      sh_blen_d   = blen_i;
    end
    // The copy reads the pre-load shadow, so a coincident load waits for the next boundary.
    if (copy_idle || copy_bnd) begin
      act_period_d = sh_period_q;
      act_duty_d   = sh_duty_q;
      act_min_d    = sh_min_q;
      act_max_d    = sh_max_q;
      act_mode_d   = sh_mode_q;
      act_blen_d   = sh_blen_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_period_q  <= CNT_W'(DEF_PERIOD);
      sh_duty_q    <= '0;
      sh_min_q     <= '0;
      sh_max_q     <= '0;
      sh_mode_q    <= MODE_CONT;
      sh_blen_q    <= '0;
      act_period_q <= CNT_W'(DEF_PERIOD);
      act_duty_q   <= '0;
      act_min_q    <= '0;
      act_max_q    <= '0;
      act_mode_q   <= MODE_CONT;
      act_blen_q   <= '0;
    end else begin
      sh_period_q  <= sh_period_d;
      sh_duty_q    <= sh_duty_d;
      sh_min_q     <= sh_min_d;
      sh_max_q     <= sh_max_d;
      sh_mode_q    <= sh_mode_d;
      sh_blen_q    <= sh_blen_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      act_min_q    <= act_min_d;
      act_max_q    <= act_max_d;
      act_mode_q   <= act_mode_d;
      act_blen_q   <= act_blen_d;
    end
  end

  assign period_o = copy_bnd ? sh_period_q : act_period_q;
  assign duty_o   = copy_bnd ? sh_duty_q   : act_duty_q;
  assign min_o    = copy_bnd ? sh_min_q    : act_min_q;
  assign max_o    = copy_bnd ? sh_max_q    : act_max_q;
  assign mode_o   = copy_bnd ? sh_mode_q   : act_mode_q;
  assign blen_o   = copy_bnd ? sh_blen_q   : act_blen_q;

endmodule

// File: rtl/pulse_wave_gen.sv
// Rectangular-wave DAC code generator with continuous, inverted, burst and off modes; advances only on tick.
// waveform/sync are registered one clk after the sampled tick; no backpressure, outputs hold between ticks.
module pulse_wave_gen
  import pulse_gen_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  pulse_wave_gen_if.slave bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BURST_W-1:0] bcnt_q, bcnt_d;
  logic [DATA_W-1:0]  wave_q, wave_d;
  logic               sync_q, sync_d;
  logic               copy_idle, copy_bnd, hi, last;
  logic [CNT_W-1:0]   c_period, c_duty;
  logic [DATA_W-1:0]  c_min, c_max;
  logic [1:0]         c_mode;
  logic [BURST_W-1:0] c_blen;

  assign copy_idle = (state_q == IDLE);
  assign copy_bnd  = (state_q != IDLE) && bus.tick && (count_q == '0);

  pulse_cfg_shadow #(
    .DATA_W  (DATA_W),
    .CNT_W   (CNT_W),
    .BURST_W (BURST_W)
  ) u_cfg (
    .clk       (clk),
    .reset     (reset),
    .load      (bus.load),
    .copy_idle (copy_idle),
    .copy_bnd  (copy_bnd),
    .period_i  (bus.period),
    .duty_i    (bus.duty),
    .min_i     (bus.minimum),
    .max_i     (bus.maximum),
    .mode_i    (bus.mode),
    .blen_i    (bus.burst_len),
    .period_o  (c_period),
    .duty_o    (c_duty),
    .min_o     (c_min),
    .max_o     (c_max),
    .mode_o    (c_mode),
    .blen_o    (c_blen)
  );

  assign hi   = count_q < c_duty;
  assign last = count_q == (c_period - 1'b1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    bcnt_d  = bcnt_q;
    wave_d  = wave_q;
    sync_d  = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (bus.tick) wave_d = c_min;
        if (c_mode == MODE_CONT || c_mode == MODE_INV) begin
          state_d = RUN;
        end else if (c_mode == MODE_BURST && bus.trigger && c_blen != '0) begin
          state_d = BURST;
          bcnt_d  = c_blen;
        end
      end
      RUN: if (bus.tick) begin
        // A boundary copy into burst/off mode ends the run on this very tick.
        if (c_mode == MODE_BURST || c_mode == MODE_OFF) begin
          state_d = IDLE;
          count_d = '0;
          wave_d  = c_min;
        end else begin
          count_d = last ? '0 : count_q + 1'b1;
          sync_d  = (count_q == '0);
          wave_d  = (hi ^ (c_mode == MODE_INV)) ? c_max : c_min;
        end
      end
      BURST: if (bus.tick) begin
        if (c_mode != MODE_BURST) begin
          state_d = IDLE;
          count_d = '0;
          wave_d  = c_min;
        end else begin
          count_d = last ? '0 : count_q + 1'b1;
          sync_d  = (count_q == '0);
          wave_d  = hi ? c_max : c_min;
          if (last) begin
            if (bcnt_q == BURST_W'(1)) state_d = IDLE;
            else                       bcnt_d  = bcnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      bcnt_q  <= '0;
      wave_q  <= '0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      bcnt_q  <= bcnt_d;
      wave_q  <= wave_d;
      sync_q  <= sync_d;
    end
  end

  assign bus.waveform = wave_q;
  assign bus.sync     = sync_q;
  assign bus.busy     = (state_q == BURST);

endmodule

// File: doc/pulse_wave_gen.md
# pulse_wave_gen

Parametrised rectangular-wave generator for the function-generator datapath. It emits DAC codes that step between `minimum` and `maximum` with programmable period and duty, and replaces the fixed 100-step pulse generator. Added capabilities: configurable period, glitch-free shadowed reconfiguration, inverted output, triggered N-period bursts and a period-start sync strobe. It runs on the system clock, is advanced by a `tick` enable from the frequency divider, and feeds the waveform mux ahead of the DAC driver.

## Interface
- `DATA_W`, 12: DAC code width.
- `CNT_W`, 8: period/duty counter width.
- `BURST_W`, 8: burst length counter width.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `tick` in 1: one-`clk` step enable; the counter advances only when it is high.
- `load` in 1: one-`clk` strobe that captures `period`, `duty`, `minimum`, `maximum`, `mode` and `burst_len` into the shadow registers.
- `period` in CNT_W: ticks per period; values 0 and 1 are clamped to 2.
- `duty` in CNT_W: high ticks per period; 0 gives a constant low level; a value of `period` or more gives a constant high level.
- `minimum`, `maximum` in DATA_W: low and high codes.
- `mode` in 2: 00 continuous, 01 inverted, 10 burst, 11 off.
- `burst_len` in BURST_W: periods per burst; 0 means a trigger is ignored.
- `trigger` in 1: level-sampled burst start, used in burst mode only.
- `waveform` out DATA_W: registered DAC code.
- `sync` out 1: one-`clk` pulse when a period starts (count 0 emitted).
- `busy` out 1: high while a burst runs.

## Operation
- Register sets:
  - Shadow set: written on `load`.
  - Active set: drives generation.
  - Shadow-to-active copy happens on the first `tick` where count is 0 (period boundary), or at once when the state is IDLE.
  - A `load` in the same cycle as a boundary copy takes effect at the next boundary.
- Counter:
  - On `tick`: count <= (count == period_a−1) ? 0 : count+1.
  - hi = count < duty_a.
- Output select on `tick`:
  - continuous: hi ? max : min.
  - inverted: hi ? min : max.
  - off, or IDLE: min.
- States: IDLE, RUN, BURST.
  - IDLE → RUN: when active mode is 00 or 01.
  - IDLE → BURST: mode 10, `trigger` high and burst_len_a ≠ 0. Count is reset to 0 and the burst counter is loaded with burst_len_a.
  - RUN → IDLE: when a boundary copy makes the mode 10 or 11.
  - BURST → IDLE: on completion of the final period. Output returns to `minimum` on the next `tick`.
  - BURST → IDLE early: when a boundary copy changes the mode.
  - `trigger` while `busy` is ignored. There is no retrigger.
- Burst counter: decrements at each period end.
- `busy` = (state == BURST).
- `sync` is emitted at the count-0 `tick` in RUN and BURST only.
- A `tick` with `load` in the same cycle: both take effect. The load goes into the shadow set, and the tick uses the active set.

## Timing
- Reset values:
  - `waveform` 0, `sync` 0, `busy` 0, count 0, state IDLE.
  - Active and shadow sets: period 100, duty 0, min 0, max 0, mode 00, burst_len 0.
- Latency: `waveform` and `sync` update one `clk` after the sampled `tick`.
- Without `tick`, outputs hold their values and `sync` is 0.
- Trigger to first burst sample: the trigger is sampled in cycle n. The first count-0 sample appears one `clk` after the next `tick` following n.
- Reset asserted mid-burst: outputs are forced to the reset values asynchronously, and any pending shadow contents are lost.
- No arithmetic overflow: count is always below period_a, which is at most 2^CNT_W−1.

## Structure
- Package `pulse_gen_pkg` holds:
  - mode encodings MODE_CONT, MODE_INV, MODE_BURST, MODE_OFF;
  - state enum IDLE/RUN/BURST;
  - reset-default constants (DEF_PERIOD = 100).
- One sub-module, `pulse_cfg_shadow`, holds the shadow and active registers, the load and boundary-copy logic, and the period clamp.
- The FSM, counters and output select stay in the top module.

## Test plan
- Reset, then load period=100, duty=30, min=0x100, max=0xE00, mode=00, with `tick` every cycle → `waveform` is 0xE00 for 30 ticks and 0x100 for 70 ticks, repeating; `sync` pulses every 100 ticks.
- Mid-period load of duty=80 at count 40 → the current period keeps 30 high ticks; the next period shows 80.
- Boundary cases:
  - duty=0 → constant 0x100 output.
  - duty=200 with period=100 → constant 0xE00 output.
  - period=0 → output toggles at period 2 (duty=1).
- Mode 10 with burst_len=3, period=10, duty=5, and a one-cycle trigger → exactly 3 pulses, `busy` high for 30 ticks, and a second trigger during the burst is ignored.
- Mode 01 → the complement of the first scenario; mode 11 → `waveform` holds 0x100 and `sync` stays 0.
- Reset asserted at tick 15 of a burst → `waveform` = 0 and `busy` = 0 in the same cycle; after release, state is IDLE with default config.
